// File: rtl/serial_parallel_loader.sv
// Serial-to-parallel front end: shifts an MSB-first bit stream into an N-bit word and strobes carga.
// Optional even-parity trailer bit enabled by defining PARITY_CHECK_EN.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for inicio
//   SHIFT   | collecting N data bits on habilita
//   PARIDAD | waiting for the parity bit (PARITY_CHECK_EN only)
//   LOAD    | carga high for one cycle, Dato holds the new word
//   ERR     | error high for one cycle, Dato untouched (PARITY_CHECK_EN only)
module serial_parallel_loader #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic         clk,
  input  logic         reset_async,
  input  logic         inicio,
  input  logic         habilita,
  input  logic         serial_in,
  output logic [N-1:0] Dato,
  output logic         carga,
  output logic         ocupado,
  output logic         error
);

`ifdef PARITY_CHECK_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    LOAD    = 3'd2,
    PARIDAD = 3'd3,
    ERR     = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;
`endif

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state;
  state_t         next_state;
  logic [N-1:0]   sr;
  logic [N-1:0]   sr_next;
  logic [CW-1:0]  cuenta;
  logic           last_bit;

  assign sr_next  = {sr[N-2:0], serial_in};
  assign last_bit = (state == SHIFT) && habilita && (cuenta == LAST);

`ifdef PARITY_CHECK_EN
  logic parity_ok;
  logic error_q;
  // Even parity: data bits plus the trailer bit must XOR to zero.
  assign parity_ok = ~(^sr ^ serial_in);
`endif

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) state <= IDLE;
    else              state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (inicio) next_state = SHIFT;
`ifdef PARITY_CHECK_EN
      SHIFT: if (last_bit) next_state = PARIDAD;
      PARIDAD: begin
        if (habilita) next_state = parity_ok ? LOAD : ERR;
      end
      ERR:   next_state = inicio ? SHIFT : IDLE;
`else
      SHIFT: if (last_bit) next_state = LOAD;
`endif
      LOAD:  next_state = inicio ? SHIFT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ocupado = (state == SHIFT);
`ifdef PARITY_CHECK_EN
    if (state == PARIDAD) ocupado = 1'b1;
    error = error_q;
`else
    error = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      sr     <= '0;
      cuenta <= '0;
      Dato   <= '0;
      carga  <= 1'b0;
`ifdef PARITY_CHECK_EN
      error_q <= 1'b0;
`endif
    end else begin
      carga <= (next_state == LOAD);
`ifdef PARITY_CHECK_EN
      error_q <= (next_state == ERR);
`endif
      if (state != SHIFT && next_state == SHIFT) begin
        cuenta <= '0;
      end else if (state == SHIFT && habilita) begin
        sr     <= sr_next;
        cuenta <= last_bit ? '0 : cuenta + 1'b1;
      end
      if (next_state == LOAD) begin
`ifdef PARITY_CHECK_EN
        // The parity bit is never shifted in, so sr already holds the word.
        Dato <= sr;
`else
        Dato <= sr_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_parallel_loader.sv
// Bench for serial_parallel_loader: vector table, hand-written corner sequences and a
// randomized run against a queue-based frame model (parity-aware when PARITY_CHECK_EN is defined).
module tb_serial_parallel_loader;
  localparam int N  = 4;
  localparam int CW = 3;
`ifdef PARITY_CHECK_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif

  logic         clk = 1'b0;
  logic         reset_async;
  logic         inicio;
  logic         habilita;
  logic         serial_in;
  logic [N-1:0] Dato;
  logic         carga;
  logic         ocupado;
  logic         error;

  serial_parallel_loader #(.N(N), .CW(CW)) dut (
    .clk         (clk),
    .reset_async (reset_async),
    .inicio      (inicio),
    .habilita    (habilita),
    .serial_in   (serial_in),
    .Dato        (Dato),
    .carga       (carga),
    .ocupado     (ocupado),
    .error       (error)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int carga_cycles[$];

  // Frame model: 0 idle, 1 collecting, 2 load cycle, 3 parity-error cycle
  int           m_mode = 0;
  bit           m_bits[$];
  logic [N-1:0] m_dato = '0;

  typedef struct {
    logic         ini;
    logic         hab;
    logic         sin;
    logic         exp_carga;
    logic         exp_ocupado;
    logic [N-1:0] exp_dato;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_update(input logic ini, input logic hab, input logic sin);
    int  word;
    bit  par;
    bit  ok;
    case (m_mode)
      0: if (ini) begin m_mode = 1; m_bits.delete(); end
      1: if (hab) begin
        m_bits.push_back(sin);
        if (m_bits.size() == FRAME) begin
          word = 0;
          par  = 0;
          for (int i = 0; i < N; i++) word = word * 2 + int'(m_bits[i]);
          for (int i = 0; i < FRAME; i++) par ^= m_bits[i];
`ifdef PARITY_CHECK_EN
          ok = (par == 0);
`else
          ok = 1;
`endif
          if (ok) begin m_dato = N'(word); m_mode = 2; end
          else m_mode = 3;
        end
      end
      default: begin
        if (ini) begin m_mode = 1; m_bits.delete(); end
        else m_mode = 0;
      end
    endcase
  endtask

  task automatic step(input logic ini, input logic hab, input logic sin);
    inicio    = ini;
    habilita  = hab;
    serial_in = sin;
    @(posedge clk);
    #1;
    cyc++;
    model_update(ini, hab, sin);
    chk("carga", 32'(carga), 32'(m_mode == 2));
    chk("Dato", 32'(Dato), 32'(m_dato));
    chk("ocupado", 32'(ocupado), 32'(m_mode == 1));
    chk("error", 32'(error), 32'(m_mode == 3));
    if (carga) carga_cycles.push_back(cyc);
  endtask

  task automatic send_word(input logic [N-1:0] w);
    logic [N-1:0] t;
    t = w;
    for (int i = N - 1; i >= 0; i--) step(1'b0, 1'b1, t[i]);
  endtask

  initial begin
    int start;
    int ini_r;
    reset_async = 1'b0;
    inicio      = 1'b0;
    habilita    = 1'b0;
    serial_in   = 1'b0;
    #12;
    chk("rst_dato", 32'(Dato), 32'h0);
    chk("rst_carga", 32'(carga), 32'h0);
    chk("rst_ocupado", 32'(ocupado), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    reset_async = 1'b1;

`ifndef PARITY_CHECK_EN
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1011};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011};
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].ini, tbl[i].hab, tbl[i].sin);
      chk("tbl_carga", 32'(carga), 32'(tbl[i].exp_carga));
      chk("tbl_ocupado", 32'(ocupado), 32'(tbl[i].exp_ocupado));
      chk("tbl_dato", 32'(Dato), 32'(tbl[i].exp_dato));
    end

    // Asynchronous reset two bits into a frame, checked between clock edges
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    #3;
    reset_async = 1'b0;
    #1;
    chk("async_rst_dato", 32'(Dato), 32'h0);
    chk("async_rst_carga", 32'(carga), 32'h0);
    chk("async_rst_ocupado", 32'(ocupado), 32'h0);
    m_mode = 0;
    m_dato = '0;
    #2;
    reset_async = 1'b1;
    carga_cycles.delete();
    step(1'b1, 1'b0, 1'b0);
    send_word(4'b1100);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("post_rst_pulses", 32'(carga_cycles.size()), 32'd1);
    chk("post_rst_dato", 32'(Dato), 32'hC);

    // Gap of three idle-habilita cycles, with inicio pulsed and serial_in toggled inside it
    carga_cycles.delete();
    step(1'b1, 1'b0, 1'b0);
    start = cyc;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("gap_dato_held", 32'(Dato), 32'hC);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("gap_pulses", 32'(carga_cycles.size()), 32'd1);
    if (carga_cycles.size() == 1) chk("gap_latency", 32'(carga_cycles[0] - start), 32'd7);
    chk("gap_dato", 32'(Dato), 32'h6);

    // Back-to-back frames, inicio held in the LOAD cycle
    carga_cycles.delete();
    step(1'b1, 1'b0, 1'b0);
    send_word(4'b1011);
    chk("b2b_first_dato", 32'(Dato), 32'hB);
    step(1'b1, 1'b0, 1'b0);
    send_word(4'b0101);
    step(1'b0, 1'b0, 1'b0);
    chk("b2b_pulses", 32'(carga_cycles.size()), 32'd2);
    if (carga_cycles.size() == 2) chk("b2b_spacing", 32'(carga_cycles[1] - carga_cycles[0]), 32'd5);
    chk("b2b_second_dato", 32'(Dato), 32'h5);
`else
    step(1'b1, 1'b0, 1'b0);
    send_word(4'b1011);
    step(1'b0, 1'b1, 1'b1);
    chk("par_ok_carga", 32'(carga), 32'h1);
    chk("par_ok_error", 32'(error), 32'h0);
    chk("par_ok_dato", 32'(Dato), 32'hB);
    step(1'b1, 1'b0, 1'b0);
    send_word(4'b0110);
    step(1'b0, 1'b1, 1'b1);
    chk("par_bad_error", 32'(error), 32'h1);
    chk("par_bad_carga", 32'(carga), 32'h0);
    chk("par_bad_dato", 32'(Dato), 32'hB);
    step(1'b0, 1'b0, 1'b0);
    chk("par_bad_error_clear", 32'(error), 32'h0);
`endif

    for (int i = 0; i < 400; i++) begin
      ini_r = ($urandom_range(0, 3) == 0) ? 1 : 0;
      step(ini_r[0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
